// File: rtl/mem_dump_uart_if.sv
// Bus bundle between the memory-dump UART stage, its host/start logic and dmem port B.
//   start      host request to begin a dump (sampled only while idle)
//   base_addr  first line address, captured on an accepted start
//   num_lines  number of lines to send, captured on an accepted start
//   mem_addr   line address driven to dmem port B
//   mem_rdata  dmem port B read data (registered read, valid one cycle after mem_addr)
//   busy       high from accepted start until the done cycle
//   done       one-cycle completion pulse
//   tx         UART serial output, idle high
interface mem_dump_uart_if;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_lines;
  logic [31:0]  mem_addr;
  logic [255:0] mem_rdata;
  logic         busy;
  logic         done;
  logic         tx;

  // Dump engine side.
  modport slave (
    input  start, base_addr, num_lines, mem_rdata,
    output mem_addr, busy, done, tx
  );

  // Host plus memory side.
  modport master (
    output start, base_addr, num_lines, mem_rdata,
    input  mem_addr, busy, done, tx
  );
endinterface

// File: rtl/mem_dump_uart.sv
// Memory-line readout over UART. On an accepted start it walks num_lines memory lines from
// base_addr, latches each 256-bit line and sends its 32 bytes as 8N1 frames (LSB first, byte 0
// first), back to back. Ends with a one-cycle done pulse.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    mem_dump_uart_if.slave: start/base_addr/num_lines in, mem_addr out to dmem port B,
//          mem_rdata in, busy/done status out, tx serial out
module mem_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] ADDR_STEP    = 32'd1
) (
  input logic             clk,
  input logic             reset,
  mem_dump_uart_if.slave  bus
);

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned BaudW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       LastByte = 5'(LINE_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StWait,
    StLatch,
    StStart,
    StData,
    StStop,
    StNext,
    StFinish
  } state_e;

  state_e       state_q, state_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [15:0]  lines_left_q, lines_left_d;
  logic [255:0] line_q, line_d;
  logic [4:0]   byte_idx_q, byte_idx_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic baud_last;
  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    lines_left_d = lines_left_q;
    line_d       = line_q;
    byte_idx_d   = byte_idx_q;
    bit_idx_d    = bit_idx_q;
    baud_d       = baud_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mem_addr_d   = bus.base_addr;
          lines_left_d = bus.num_lines;
          state_d      = (bus.num_lines == 16'd0) ? StFinish : StAddr;
        end
      end
      StAddr: state_d = StWait;
      StWait: state_d = StLatch;
      StLatch: begin
        // Line is captured once here; later mem_rdata activity cannot disturb the frames.
        line_d     = bus.mem_rdata;
        byte_idx_d = '0;
        bit_idx_d  = '0;
        baud_d     = '0;
        state_d    = StStart;
      end
      StStart: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_idx_q != LastByte) begin
            byte_idx_d = byte_idx_q + 5'd1;
            state_d    = StStart;
          end else begin
            state_d = StNext;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StNext: begin
        lines_left_d = lines_left_q - 16'd1;
        if (lines_left_q == 16'd1) begin
          state_d = StFinish;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_STEP;
          state_d    = StAddr;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up with the state
  // they belong to, keeping tx glitch-free and exactly aligned to bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = line_d[{byte_idx_d, bit_idx_d}];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      lines_left_q <= '0;
      line_q       <= '0;
      byte_idx_q   <= '0;
      bit_idx_q    <= '0;
      baud_q       <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      lines_left_q <= lines_left_d;
      line_q       <= line_d;
      byte_idx_q   <= byte_idx_d;
      bit_idx_q    <= bit_idx_d;
      baud_q       <= baud_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mem_dump_uart.sv
// Self-checking bench for mem_dump_uart with CLKS_PER_BIT=4. A cycle-level expectation queue is
// built from the frame rules (per line: 3 setup cycles, 32 frames of 10 bits, 1 step cycle; then
// one done cycle) and compared every cycle; a UART decoder recovers bytes from tx.
module tb_mem_dump_uart;
  localparam int unsigned C          = 4;
  localparam int unsigned LineCycles = 4 + 320 * C;

  logic clk = 1'b0;
  logic reset;

  mem_dump_uart_if bus ();

  mem_dump_uart #(
    .CLKS_PER_BIT(C),
    .ADDR_STEP   (32'd1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        tx;
    logic        busy;
    logic        done;
    logic [31:0] addr;
    logic        latch;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_bytes[$];
  logic       scramble = 1'b0;
  logic [31:0] prev_addr = '0;

  // Memory contents: line 5 holds byte k = k+1, every other line a simple address hash.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) begin
      if (a == 32'd5) v[8*k +: 8] = 8'(k + 1);
      else            v[8*k +: 8] = a[7:0] * 8'd37 + 8'(k) * 8'd11 + 8'd3;
    end
    return v;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic push_exp(input logic tx, input logic done, input logic [31:0] addr,
                          input logic latch);
    exp_t e;
    e.tx = tx; e.busy = 1'b1; e.done = done; e.addr = addr; e.latch = latch;
    exp_q.push_back(e);
  endtask

  task automatic build_exp(input logic [31:0] base, input int n);
    logic [31:0]  addr;
    logic [255:0] data;
    logic         v;
    exp_q.delete();
    exp_bytes.delete();
    for (int l = 0; l < n; l++) begin
      addr = base + 32'(l);
      data = line_of(addr);
      for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, addr, i == 2);
      for (int b = 0; b < 32; b++) begin
        exp_bytes.push_back(data[8*b +: 8]);
        for (int s = 0; s < 10; s++) begin
          if (s == 0)      v = 1'b0;
          else if (s == 9) v = 1'b1;
          else             v = data[8*b + s - 1];
          for (int c = 0; c < C; c++) push_exp(v, 1'b0, addr, 1'b0);
        end
      end
      push_exp(1'b1, 1'b0, addr, 1'b0);
    end
    push_exp(1'b1, 1'b1, (n == 0) ? base : base + 32'(n - 1), 1'b0);
  endtask

  // Per-cycle compare against the expectation queue, or against idle/reset values.
  exp_t cur;
  always @(negedge clk) begin
    prev_addr = bus.mem_addr;
    checks++;
    if (reset) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_addr !== 32'd0) begin
        errors++;
        $display("FAIL reset_state: tx=%b busy=%b done=%b addr=%h, want tx=1 busy=0 done=0 addr=0",
                 bus.tx, bus.busy, bus.done, bus.mem_addr);
      end
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (bus.tx !== cur.tx || bus.busy !== cur.busy || bus.done !== cur.done ||
          bus.mem_addr !== cur.addr) begin
        errors++;
        $display("FAIL cycle @%0t: tx=%b busy=%b done=%b addr=%h, want tx=%b busy=%b done=%b addr=%h",
                 $time, bus.tx, bus.busy, bus.done, bus.mem_addr,
                 cur.tx, cur.busy, cur.done, cur.addr);
      end
    end else begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL idle @%0t: tx=%b busy=%b done=%b, want tx=1 busy=0 done=0",
                 $time, bus.tx, bus.busy, bus.done);
      end
    end
  end

  // Registered-read memory model; in scramble mode only the latch cycle sees true data.
  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    #1;
    if (scramble && !(exp_q.size() > 0 && exp_q[0].latch)) bus.mem_rdata = rand_line();
    else                                                   bus.mem_rdata = line_of(prev_addr);
  end

  // UART receiver sampling mid-bit.
  int         rx_cnt = -1;
  logic [7:0] rx_sh  = '0;
  always @(negedge clk) begin
    if (reset) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (bus.tx == 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if ((rx_cnt % C) == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
        rx_sh[rx_cnt / C - 1] = bus.tx;
      if (rx_cnt == 9 * C + C / 2) begin
        rx_bytes.push_back(rx_sh);
        rx_cnt = -1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic check_bytes(input string name);
    int bad;
    bad = (rx_bytes.size() != exp_bytes.size()) ? 1 : 0;
    if (bad == 0)
      for (int i = 0; i < rx_bytes.size(); i++) if (rx_bytes[i] !== exp_bytes[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes (%0d wrong), want %0d bytes", name, rx_bytes.size(), bad,
               exp_bytes.size());
    end
  endtask

  // Called just after a negedge. Returns cycles from accept to done (ADDR cycle = 1).
  task automatic run_dump(input logic [31:0] base, input int n, input int poke_at,
                          output int done_at);
    int cnt;
    build_exp(base, n);
    rx_bytes.delete();
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_lines = 16'(n);
    @(posedge clk);
    #1 bus.start = 1'b0;
    cnt     = 0;
    done_at = -1;
    while (cnt < n * LineCycles + 20) begin
      @(negedge clk);
      cnt++;
      if (bus.start) #1 bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_at = cnt;
        break;
      end
      if (cnt == poke_at) begin
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 32'hDEAD_0000;
        bus.num_lines = 16'd7;
      end
    end
    if (done_at < 0) check("done_timeout", 64'(cnt), 64'(n * LineCycles + 1));
    repeat (4) @(negedge clk);
    #1;
  endtask

  int d;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_lines = '0;
    #1;
    check("async_reset_tx", 64'(bus.tx), 64'd1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;

    // Single line at address 5.
    run_dump(32'd5, 1, -1, d);
    check("single_done_at", 64'(d), 64'd1285);
    check("single_nbytes", 64'(rx_bytes.size()), 64'd32);
    check("single_first_byte", 64'(rx_bytes[0]), 64'h01);
    check("single_last_byte", 64'(rx_bytes[31]), 64'h20);
    check_bytes("single_bytes");
    check("single_busy_after", 64'(bus.busy), 64'd0);

    // Zero lines.
    run_dump(32'h0000_1234, 0, -1, d);
    check("zero_done_at", 64'(d), 64'd1);
    check("zero_mem_addr", 64'(bus.mem_addr), 64'h1234);
    check("zero_nbytes", 64'(rx_bytes.size()), 64'd0);

    // Three lines wrapping through 0.
    run_dump(32'hFFFF_FFFF, 3, -1, d);
    check("wrap_done_at", 64'(d), 64'd3853);
    check("wrap_nbytes", 64'(rx_bytes.size()), 64'd96);
    check("wrap_line0_byte0", 64'(rx_bytes[0]), 64'hDE);
    check("wrap_line1_byte0", 64'(rx_bytes[32]), 64'h03);
    check_bytes("wrap_bytes");
    check("wrap_final_addr", 64'(bus.mem_addr), 64'h1);

    // Start while busy is ignored.
    run_dump(32'd5, 1, 200, d);
    check("busy_start_done_at", 64'(d), 64'd1285);
    check_bytes("busy_start_bytes");
    repeat (20) @(negedge clk);
    #1;

    // Reset during data bits of byte 10.
    build_exp(32'h100, 2);
    rx_bytes.delete();
    bus.start     = 1'b1;
    bus.base_addr = 32'h100;
    bus.num_lines = 16'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3 + 100 * C + C + 3 * C) @(negedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_tx", 64'(bus.tx), 64'd1);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_nbytes", 64'(rx_bytes.size()), 64'd10);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    run_dump(32'h200, 1, -1, d);
    check("post_reset_done_at", 64'(d), 64'd1285);
    check_bytes("post_reset_bytes");

    // mem_rdata garbage except on the latch cycle.
    scramble = 1'b1;
    run_dump(32'h40, 2, -1, d);
    scramble = 1'b0;
    check("hold_done_at", 64'(d), 64'd2569);
    check_bytes("hold_bytes");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
